// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the 4x4 CHIP-8 keypad scanner.
// Optional build macro KEYPAD_GHOST_REJECT_EN uses is_ghost() below.
package keypad_pkg;

  localparam int NUM_ROWS = 4;

  // Physical position (row*4 + col) -> CHIP-8 key number
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hC,
    4'h4, 4'h5, 4'h6, 4'hD,
    4'h7, 4'h8, 4'h9, 4'hE,
    4'hA, 4'h0, 4'hB, 4'hF
  };

  // Bit 2 marks an active row; bits [1:0] are the row index.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_ROW0 = 3'b100,
    ST_ROW1 = 3'b101,
    ST_ROW2 = 3'b110,
    ST_ROW3 = 3'b111
  } row_state_e;

  function automatic logic [3:0] row_cols(input logic [15:0] keys, input int r);
    logic [3:0] cols;
    for (int c = 0; c < 4; c++) cols[c] = keys[KEYMAP[r*4+c]];
    return cols;
  endfunction

  // Two rows sharing two pressed columns make the fourth corner ambiguous
  function automatic logic is_ghost(input logic [15:0] keys);
    logic ghost;
    ghost = 1'b0;
    for (int a = 0; a < NUM_ROWS - 1; a++)
      for (int b = a + 1; b < NUM_ROWS; b++)
        if ($countones(row_cols(keys, a) & row_cols(keys, b)) >= 2) ghost = 1'b1;
    return ghost;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Scan-level debouncer: matrix follows raw after DEBOUNCE_SCANS identical scans.
// With KEYPAD_GHOST_REJECT_EN defined, ghost-ambiguous scans are discarded.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] raw_i,
  input  logic        done_i,
  output logic [15:0] matrix_o,
  output logic        key_event_o,
  output logic [3:0]  key_code_o
);

  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SAT = SW'(DEBOUNCE_SCANS);

  logic [15:0]   prev_q, prev_d, matrix_q, matrix_d, new_bits;
  logic [SW-1:0] stable_q, stable_d;
  logic          event_q, event_d, accept;
  logic [3:0]    code_q, code_d;

`ifdef KEYPAD_GHOST_REJECT_EN
  assign accept = !is_ghost(raw_i);
`else
  assign accept = 1'b1;
`endif

  assign new_bits = raw_i & ~matrix_q;

  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    matrix_d = matrix_q;
    event_d  = 1'b0;
    code_d   = code_q;
    if (done_i) begin
      if (!accept) begin
        stable_d = '0;
      end else begin
        prev_d = raw_i;
        if (raw_i != prev_q)    stable_d = SW'(1);
        else if (stable_q < SAT) stable_d = stable_q + 1'b1;
        if (stable_d == SAT && raw_i != matrix_q) begin
          matrix_d = raw_i;
          // Pure releases update the matrix silently
          if (|new_bits) begin
            event_d = 1'b1;
            code_d  = lowest_set(new_bits);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q   <= '0;
      stable_q <= '0;
      matrix_q <= '0;
      event_q  <= 1'b0;
      code_q   <= '0;
    end else begin
      prev_q   <= prev_d;
      stable_q <= stable_d;
      matrix_q <= matrix_d;
      event_q  <= event_d;
      code_q   <= code_d;
    end
  end

  assign matrix_o    = matrix_q;
  assign key_event_o = event_q;
  assign key_code_o  = code_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 CHIP-8 keypad scanner: row drive, column synchronizer, sampling, debounce.
// Build macro KEYPAD_GHOST_REJECT_EN (in keypad_debounce) discards ghost-ambiguous scans.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1024,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic [15:0] matrix,
  output logic        key_event,
  output logic [3:0]  key_code
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  row_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    sync1_q, sync2_q;
  logic [15:0]   raw_q, raw_d;
  logic [1:0]    row_idx;
  logic          done;

  assign row_idx = state_q[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raw_d   = raw_q;
    done    = 1'b0;
    row_n   = 4'hF;
    case (state_q)
      ST_IDLE: state_d = ST_ROW0;
      default: begin
        row_n = ~(4'b0001 << row_idx);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // raw_d carries the completed scan straight into the debouncer
          for (int c = 0; c < 4; c++) raw_d[KEYMAP[{row_idx, 2'(c)}]] = ~sync2_q[c];
          done    = (state_q == ST_ROW3);
          state_d = row_state_e'({1'b1, row_idx + 2'd1});
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      raw_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync1_q <= col_n;
      sync2_q <= sync1_q;
      raw_q   <= raw_d;
    end
  end

  keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .raw_i      (raw_d),
    .done_i     (done),
    .matrix_o   (matrix),
    .key_event_o(key_event),
    .key_code_o (key_code)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed bench for keypad_scanner against a scan-level keypad model.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DS = 3;
  localparam int LBL [4][4] = '{'{1, 2, 3, 12}, '{4, 5, 6, 13}, '{7, 8, 9, 14}, '{10, 0, 11, 15}};

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row_n, col_n;
  logic [15:0] matrix;
  logic        key_event;
  logic [3:0]  key_code;
  logic [15:0] pressed;   // physical switches, bit r*4+c

  int nvec = 0, nerr = 0, evt_cnt = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n),
    .matrix(matrix), .key_event(key_event), .key_code(key_code)
  );

  // Resistive matrix: a driven row pulls every column reachable through closed switches
  function automatic logic [3:0] sense(input logic [15:0] pk, input logic [3:0] rown);
    logic [3:0] rows, cols;
    rows = ~rown;
    cols = 4'h0;
    repeat (4)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (pk[r*4+c] && (rows[r] || cols[c])) begin
            rows[r] = 1'b1;
            cols[c] = 1'b1;
          end
    return ~cols;
  endfunction

  assign col_n = sense(pressed, row_n);

  // Reference model state
  int          t = -1;
  int          m_stable;
  logic [15:0] m_scan, m_prev, m_matrix;
  logic        m_evt;
  logic [3:0]  m_code;
  logic [3:0]  hist [4];
  logic [3:0]  phys [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic scan_done();
    logic        ghost;
    logic [15:0] nb;
    ghost = 1'b0;
`ifdef KEYPAD_GHOST_REJECT_EN
    for (int a = 0; a < 3; a++)
      for (int b = a + 1; b < 4; b++)
        if ($countones(phys[a] & phys[b]) >= 2) ghost = 1'b1;
`endif
    if (ghost) begin
      m_stable = 0;
    end else begin
      m_stable = (m_scan == m_prev) ? ((m_stable + 1 > DS) ? DS : m_stable + 1) : 1;
      m_prev   = m_scan;
      if (m_stable == DS && m_scan != m_matrix) begin
        nb       = m_scan & ~m_matrix;
        m_matrix = m_scan;
        if (nb != 0) begin
          m_evt = 1'b1;
          for (int i = 15; i >= 0; i--) if (nb[i]) m_code = 4'(i);
        end
      end
    end
  endtask

  task automatic model_edge();
    int r;
    m_evt = 1'b0;
    if (!reset) begin
      t = -1; m_stable = 0; m_scan = '0; m_prev = '0; m_matrix = '0; m_code = '0;
      for (int i = 0; i < 4; i++) phys[i] = '0;
    end else if (t < 0) begin
      t = 0;
    end else begin
      if (t % SD == SD - 1) begin
        r = (t / SD) % 4;
        phys[r] = hist[(t - 2) % 4];
        for (int c = 0; c < 4; c++) m_scan[LBL[r][c]] = phys[r][c];
        if (r == 3) scan_done();
      end
      t++;
    end
  endtask

  // One clock cycle with the current inputs; checks mid-cycle, advances model at the edge
  task automatic cyc();
    logic [3:0] drv, exp_row;
    drv = (t >= 0) ? ~(4'b0001 << ((t / SD) % 4)) : 4'hF;
    if (t >= 0) hist[t % 4] = ~sense(pressed, drv);
    exp_row = drv;
    @(negedge clk);
    chk("row_n", row_n, exp_row);
    chk("matrix", matrix, m_matrix);
    chk("key_event", key_event, m_evt);
    chk("key_code", key_code, m_code);
    if (key_event === 1'b1) evt_cnt++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic align(input int phase);
    int guard;
    guard = 0;
    while (t < 0 || (t % (4 * SD)) != phase) begin
      cyc();
      guard++;
      if (guard > 100) begin
        chk("align_timeout", guard, 0);
        break;
      end
    end
  endtask

  initial begin
    int e0;
    reset   = 1'b0;
    pressed = '0;
    @(posedge clk);
    model_edge();
    #1;

    // Reset held for 5 cycles, then release and watch the row walk
    run(5);
    chk("rst_row_n", row_n, 4'hF);
    chk("rst_matrix", matrix, 16'h0);
    chk("rst_event", key_event, 1'b0);
    reset = 1'b1;
    run(1);
    chk("first_row", row_n, 4'hE);
    run(4 * SD * 2);

    // Single press at physical row1 col2 -> key 6
    e0 = evt_cnt;
    pressed = 16'h0040;
    run(4 * SD * 5);
    chk("single_matrix", matrix, 16'h0040);
    chk("single_code", key_code, 4'h6);
    chk("single_events", evt_cnt - e0, 1);

    // Bounce from a released, settled state
    pressed = '0;
    run(4 * SD * 5);
    align(0);
    e0 = evt_cnt;
    for (int i = 0; i < 8; i++) begin
      pressed = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      run(10);
      chk("bounce_hold0", matrix, 16'h0);
    end
    pressed = 16'h0040;
    run(4 * SD * 5);
    chk("bounce_matrix", matrix, 16'h0040);
    chk("bounce_events", evt_cnt - e0, 1);

    // Two keys (row0col0, row3col3), then release both
    pressed = '0;
    run(4 * SD * 5);
    e0 = evt_cnt;
    pressed = 16'h8001;
    run(4 * SD * 5);
    chk("two_matrix", matrix, 16'h8002);
    chk("two_code", key_code, 4'h1);
    chk("two_events", evt_cnt - e0, 1);
    pressed = '0;
    run(4 * SD * 5);
    chk("rel_matrix", matrix, 16'h0);
    chk("rel_events", evt_cnt - e0, 1);

    // Reset while row 2 is driven with a key held
    pressed = 16'h0040;
    run(4 * SD * 5);
    align(2 * SD + 1);
    reset = 1'b0;
    run(3);
    chk("midrst_row_n", row_n, 4'hF);
    chk("midrst_matrix", matrix, 16'h0);
    chk("midrst_code", key_code, 4'h0);
    reset = 1'b1;
    run(4 * SD * DS);
    chk("midrst_early", matrix, 16'h0);
    run(4 * SD * 2);
    chk("midrst_after", matrix, 16'h0040);

    // Keys 1, 2, 4 pressed: the matrix also senses a ghost 5
    pressed = '0;
    run(4 * SD * 5);
    e0 = evt_cnt;
    pressed = 16'h0013;
    run(4 * SD * 5);
`ifdef KEYPAD_GHOST_REJECT_EN
    chk("ghost_matrix", matrix, 16'h0);
    chk("ghost_events", evt_cnt - e0, 0);
`else
    chk("ghost_matrix", matrix, 16'h0036);
    chk("ghost_events", evt_cnt - e0, 1);
`endif

    // Random sparse patterns with random hold times, occasional short glitches
    for (int k = 0; k < 40; k++) begin
      pressed = 16'($urandom & $urandom & $urandom);
      run($urandom_range(8, 90));
      if ($urandom_range(0, 3) == 0) begin
        pressed = '0;
        run($urandom_range(1, 12));
      end
    end
    pressed = '0;
    run(4 * SD * 5);
    chk("final_matrix", matrix, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a physical 4x4 CHIP-8 hex keypad by driving rows and reading columns, then debounces the result. Outputs a 16-bit keypad matrix, bit n = CHIP-8 key n pressed. Drop-in replacement for the switch-based matrix source feeding cpu.keypad_matrix on real boards. Also gives a one-cycle new-key event for future wait-for-key acceleration.

Parameters:
SCAN_DIV, 1024, clock cycles each row is driven before its columns are sampled (min 4)
DEBOUNCE_SCANS, 4, consecutive identical full scans required before matrix updates (min 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
row_n  output  4  row drive, active-low one-hot; 4'hF = no row driven
col_n  input  4  column sense, active-low, externally pulled up, asynchronous
matrix  output  16  debounced keys, bit n = CHIP-8 key n
key_event  output  1  one-cycle pulse when matrix gains at least one newly set bit
key_code  output  4  CHIP-8 key number of the lowest newly set bit; held until next event

Behaviour:
- Reset (reset==0 at a clk edge): row_n=4'hF, matrix=0, key_event=0, key_code=0, row index=0, dwell counter=0, raw scan=0, prev_raw=0, stable count=0. Reset mid-scan discards the partial scan.
- col_n passes through a 2-flop synchronizer before use.
- Row FSM (row r = 0..3): the first cycle after reset release drives row_n with bit r low. The dwell counter counts 0..SCAN_DIV-1. On count SCAN_DIV-1, ~col_sync is latched into raw[r*4+c]. Then r advances, wrapping 3->0, and the counter clears. Rows are contiguous with no idle gap. A full scan takes 4*SCAN_DIV cycles.
- Physical-to-CHIP-8 map. Row 0: 1 2 3 C. Row 1: 4 5 6 D. Row 2: 7 8 9 E. Row 3: A 0 B F. Column index runs left to right. The map is applied when building raw, so raw is already in CHIP-8 bit order.
- Scan completion happens on the cycle row 3 is sampled. At completion:
  - if raw_new==prev_raw, stable count <= min(count+1, DEBOUNCE_SCANS); otherwise stable count <= 1.
  - prev_raw <= raw_new.
- Matrix update: if the updated stable count equals DEBOUNCE_SCANS and raw_new != matrix, then matrix <= raw_new on the cycle after completion. key_event is asserted on that same cycle if (raw_new & ~matrix_old) != 0. In that case key_code = index of the lowest set bit of raw_new & ~matrix_old.
- Releases clear matrix bits without a key_event. Simultaneous press and release in one update still pulses for the press.
- No events are generated while the stable count is saturated and raw is unchanged.

Optional Feature:
KEYPAD_GHOST_REJECT_EN.
- Defined: at scan completion, if any two rows share two or more pressed columns (rectangle, ghost-ambiguous), the scan is discarded. Stable count <= 0, prev_raw unchanged, matrix held.
- Undefined: all scans are accepted as-is.

Decomposition:
- Shared package keypad_pkg: the 16-entry physical-to-CHIP-8 map constant, the row-count constant 4, and the row FSM state encoding.
- One sub-module, keypad_debounce: takes the raw scan and a completion strobe; produces matrix, key_event, key_code. The scanner top handles row drive, the synchronizer and sampling.

Test Plan:
(All with SCAN_DIV=4, DEBOUNCE_SCANS=3; full scan = 16 cycles.)
- Reset: hold reset low for 5 cycles -> row_n=F, matrix=0, key_event=0. Release -> row_n=E next cycle, then D, B, 7, each held 4 cycles, repeating.
- Single press, physical row1 col2, stable -> after 3 complete scans, matrix=16'h0040, key_event pulses exactly once, key_code=6.
- Bounce: toggle that key every 10 cycles for 80 cycles, then hold -> matrix stays 0 during bouncing. It updates only after 3 identical scans, with exactly one key_event.
- Two keys, row0col0 and row3col3, together -> matrix=16'h8002, key_code=1. Release both -> matrix=0 after 3 scans, no key_event.
- Reset asserted while row 2 is driven with a key held -> outputs return to reset values. Debounce restarts from the first full scan after release.
- KEYPAD_GHOST_REJECT_EN: press keys 1, 2 and 4 (rows 0/1, cols 0/1; the sensed pattern also shows 5) -> matrix stays 0 and no key_event. Without the macro -> matrix=16'h0036.
